// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift-register sequencer: FU select codes and controller states.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_LOAD    = 3'd1,
    OP_SHR_SER = 3'd2,
    OP_SHL_SER = 3'd3,
    OP_ROR     = 3'd4,
    OP_ROL     = 3'd5,
    OP_ASR     = 3'd6,
    OP_LSL     = 3'd7
  } fu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and response handshakes between a requester (master) and the sequencer (slave).
interface shift_sequencer_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N) + 1
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic          cmd_load;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_data, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Drives an external universal shift register through load + N-step shift/rotate commands,
// advancing one step per step_en tick and returning the final register value.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_sequencer_if.slave     bus,
  input  logic                 step_en,
  input  logic                 ser_in,
  output logic                 ser_out,
  output logic [$clog2(N)-1:0] fu_s,
  output logic [N-1:0]         fu_d,
  output logic                 fu_msb_in,
  output logic                 fu_lsb_in,
  input  logic [N-1:0]         fu_q,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(N);

  seq_state_e    state;
  fu_op_e        op_q;
  logic [N-1:0]  data_q;
  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_HOLD;
      data_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= fu_op_e'(bus.cmd_op);
            data_q    <= bus.cmd_data;
            remaining <= bus.cmd_count;
            if (bus.cmd_load)              state <= ST_LOAD;
            else if (bus.cmd_count != '0)  state <= ST_SHIFT;
            else                           state <= ST_RESP;
          end
        end
        ST_LOAD: state <= (remaining != '0) ? ST_SHIFT : ST_RESP;
        ST_SHIFT: begin
          if (step_en) begin
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) state <= ST_RESP;
          end
        end
        ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Select is gated by rst so a step coinciding with reset never reaches the FU.
  always_comb begin
    fu_s      = '0;
    fu_msb_in = 1'b0;
    fu_lsb_in = 1'b0;
    ser_out   = 1'b0;
    if (!rst && state == ST_LOAD) fu_s = SW'(OP_LOAD);
    if (state == ST_SHIFT) begin
      if (!rst && step_en && op_q != OP_HOLD && op_q != OP_LOAD) fu_s = SW'(op_q);
      fu_msb_in = (op_q == OP_SHR_SER) ? ser_in : 1'b0;
      fu_lsb_in = (op_q == OP_SHL_SER) ? ser_in : 1'b0;
      case (op_q)
        OP_SHR_SER, OP_ROR, OP_ASR: ser_out = fu_q[0];
        OP_SHL_SER, OP_ROL, OP_LSL: ser_out = fu_q[N-1];
        default:                    ser_out = 1'b0;
      endcase
    end
  end

  assign fu_d          = data_q;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = fu_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that sequences the N-bit universal shift register (FunctionalUnit) through multi-step shift/rotate commands.
- Accepts one command per transaction over a valid/ready handshake. Optionally loads a word, then issues the selected op once per step_en pulse for cmd_count steps, then returns the final register value on a response handshake.
- step_en is the bit-timing tick (e.g. SCL-derived in the I2C path), so one command can shift a full I2C byte in or out.

Parameters:
- N, 8, width of the shift register being sequenced.
- CW, $clog2(N)+1, width of step count; range 0..2^CW-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  3  FU select used for shift steps (encoding below).
- cmd_load  input  1  1: load cmd_data before shifting.
- cmd_data  input  N  load value.
- cmd_count  input  CW  number of shift steps.
- step_en  input  1  advance one shift step this cycle.
- ser_in  input  1  serial bit fed into FU MSBIn/LSBIn.
- ser_out  output  1  bit leaving the register on the current step.
- fu_s  output  $clog2(N)  to FU select S.
- fu_d  output  N  to FU D.
- fu_msb_in  output  1  to FU MSBIn.
- fu_lsb_in  output  1  to FU LSBIn.
- fu_q  input  N  FU Q.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed.
- rsp_data  output  N  final register value.
- busy  output  1  not IDLE.

Behaviour:
- FU select encoding:
  - 0 hold, 1 load D.
  - 2 shift right with MSBIn, 3 shift left with LSBIn.
  - 4 rotate right, 5 rotate left.
  - 6 arithmetic shift right, 7 logical shift left.
- States: IDLE, LOAD, SHIFT, RESP.
- Reset: state=IDLE; fu_s=0, fu_d=0, fu_msb_in=0, fu_lsb_in=0, rsp_valid=0, busy=0, cmd_ready=1 the cycle after rst deasserts.
- The FU register has its own reset; this block never drives load on reset.
- IDLE:
  - fu_s=0.
  - On cmd_valid&&cmd_ready, latch op, data and count.
  - Next state: LOAD if cmd_load; else SHIFT if count!=0; else RESP.
- LOAD:
  - Exactly one cycle, fu_s=1, fu_d=latched data.
  - Next state: SHIFT if count!=0, else RESP.
- SHIFT:
  - step_en=1: fu_s=op and remaining decrements.
  - step_en=0: fu_s=0 (hold) and the count is unchanged.
  - On the step where remaining==1, go to RESP.
  - Exactly cmd_count FU updates occur.
- Op 0 or 1 as cmd_op: fu_s forced to 0 every step. The block still consumes cmd_count steps as a pure delay, and the register is unchanged.
- fu_msb_in = ser_in when op==2, else 0. fu_lsb_in = ser_in when op==3, else 0. Both are combinational during SHIFT.
- ser_out (combinational):
  - fu_q[0] for ops 2, 4, 6.
  - fu_q[N-1] for ops 3, 5, 7.
  - 0 otherwise and outside SHIFT.
- RESP:
  - fu_s=0, rsp_valid=1, rsp_data=fu_q, stable until rsp_valid&&rsp_ready.
  - On handshake, go to IDLE.
  - Latency from the last step to rsp_valid is 1 cycle, because the FU updates on the same edge.
- cmd_ready=0 in LOAD, SHIFT and RESP; commands offered then are not accepted.
- Counts above N are legal: rotations wrap modulo N, and shifts saturate to the fill pattern.
- rst during any state: next cycle IDLE, an in-flight response is dropped, and no partial FU op is issued after reset.
- step_en during IDLE, LOAD or RESP is ignored.

Decomposition:
- shift_seq_pkg holds:
  - fu_op_e enum (HOLD, LOAD, SHR_SER, SHL_SER, ROR, ROL, ASR, LSL) with the encoding above.
  - seq_state_e (IDLE, LOAD, SHIFT, RESP).
- No sub-module. The step counter stays inline with the FSM; ser_out and serial muxing are combinational in the same module.

Test Plan (N=8):
- Load 0xA5, op=ROR, count=3, step_en every cycle -> exactly 3 non-hold fu_s cycles; rsp_data=0xB4.
- Load 0x90, op=ASR, count=2, step_en every 3rd cycle -> fu_s=0 on non-step cycles; rsp_data=0xE4; busy throughout.
- Load 0x0F, op=SHL_SER, count=3, ser_in=1,0,1 -> ser_out=0,0,0; rsp_data=0x7D.
- Load 0xFF, op=LSL, count=8 -> rsp_data=0x00. Then without load, op=ROL, count=0 -> direct IDLE->RESP, rsp_data=0x00.
- Load 0x3C, count=0 -> LOAD then RESP, rsp_data=0x3C. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
- Assert rst mid-SHIFT after 2 of 5 steps -> IDLE next cycle, rsp_valid=0, cmd_ready=1. A new command is then accepted normally.
